// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the UART configuration loader.
// Optional idle timeout is enabled by defining CFG_LOADER_TIMEOUT_EN.
package cfg_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        WORD_HUNT,
        WORD_LOAD
    } word_state_t;

    localparam logic [31:0] DEFAULT_SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DEFAULT_DESYNC_WORD = 32'hFAB0_FAB0;
    localparam int          BYTE_CNT_W          = 2;

    // Bytes enter at the bottom so the first byte of a word ends up in [31:24].
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word, input logic [7:0] data);
        return {word[23:0], data};
    endfunction

endpackage

// File: rtl/uart_cfg_loader_if.sv
// Configuration write port and status signals driven by the loader.
interface uart_cfg_loader_if;

    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        ComActive;
    logic        ReceiveLED;
    logic        FrameErr;

    modport master (
        output WriteData,
        output WriteStrobe,
        output ComActive,
        output ReceiveLED,
        output FrameErr
    );

    modport slave (
        input WriteData,
        input WriteStrobe,
        input ComActive,
        input ReceiveLED,
        input FrameErr
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser plus bit-level FSM.
// byte_valid / frame_err are single-cycle strobes in the stop-bit sample cycle.
module uart_rx_byte
    import cfg_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks_per_bit
        $error("uart_rx_byte: CLKS_PER_BIT must be even and at least 4");
    end

    logic [1:0]       sync_reg;
    logic             rx_s;
    rx_state_t        state_reg;
    rx_state_t        state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             cnt_zero;

    assign rx_s     = sync_reg[1];
    assign cnt_zero = (cnt_reg == '0);
    assign rx_byte  = shift_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= RX_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RX_IDLE:  if (!rx_s) state_next = RX_START;
            RX_START: if (cnt_zero) state_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_zero && bit_idx_reg == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (cnt_zero) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    // Counter is preloaded in IDLE so START samples mid-bit.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            case (state_reg)
                RX_IDLE: begin
                    cnt_reg <= HALF_BIT;
                end
                RX_START: begin
                    if (cnt_zero) begin
                        cnt_reg     <= FULL_BIT;
                        bit_idx_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_zero) begin
                        cnt_reg     <= FULL_BIT;
                        shift_reg   <= {rx_s, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (!cnt_zero) cnt_reg <= cnt_reg - CNT_W'(1);
                end
                default: begin
                    cnt_reg <= HALF_BIT;
                end
            endcase
        end
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (state_reg == RX_STOP && cnt_zero) begin
            byte_valid = rx_s;
            frame_err  = !rx_s;
        end
    end

endmodule

// File: rtl/uart_cfg_loader.sv
// UART bitstream loader: hunts for the sync word, then packs bytes MSB-first
// into 32-bit config writes. Define CFG_LOADER_TIMEOUT_EN for the LOAD idle timeout.
module uart_cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT   = 8,
    parameter logic [31:0] SYNC_WORD      = DEFAULT_SYNC_WORD,
    parameter logic [31:0] DESYNC_WORD    = DEFAULT_DESYNC_WORD,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Rx,
    uart_cfg_loader_if.master  cfg
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_cfg_loader: TIMEOUT_CYCLES must be at least 1");
    end

    logic [7:0]            rx_byte;
    logic                  byte_valid;
    logic                  frame_err;
    word_state_t           word_state_reg;
    word_state_t           word_state_next;
    logic [31:0]           win_reg;
    logic [31:0]           win_shifted;
    logic [BYTE_CNT_W-1:0] byte_cnt_reg;
    logic                  word_done;
    logic                  timeout_hit;
    logic                  strobe_next;
    logic [31:0]           write_data_reg;
    logic                  write_strobe_reg;
    logic                  receive_led_reg;
    logic                  frame_err_reg;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk        (CLK),
        .srst       (RST),
        .rx         (Rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign win_shifted = shift_in_byte(win_reg, rx_byte);
    assign word_done   = byte_valid && (word_state_reg == WORD_LOAD) && (byte_cnt_reg == '1);

`ifdef CFG_LOADER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt_reg;

    always_ff @(posedge CLK) begin
        if (RST || word_state_reg != WORD_LOAD || byte_valid || frame_err) begin
            idle_cnt_reg <= '0;
        end else if (!timeout_hit) begin
            idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
        end
    end

    assign timeout_hit = (word_state_reg == WORD_LOAD) && (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            word_state_reg <= WORD_HUNT;
        end else begin
            word_state_reg <= word_state_next;
        end
    end

    always_comb begin
        word_state_next = word_state_reg;
        case (word_state_reg)
            WORD_HUNT: begin
                if (byte_valid && win_shifted == SYNC_WORD) word_state_next = WORD_LOAD;
            end
            WORD_LOAD: begin
                if (timeout_hit) begin
                    word_state_next = WORD_HUNT;
                end else if (word_done && win_shifted == DESYNC_WORD) begin
                    word_state_next = WORD_HUNT;
                end
            end
            default: word_state_next = WORD_HUNT;
        endcase
    end

    // A repeated sync word inside LOAD just realigns; it is never written.
    always_comb begin
        strobe_next = word_done && !timeout_hit
                   && (win_shifted != SYNC_WORD) && (win_shifted != DESYNC_WORD);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            win_reg          <= '0;
            byte_cnt_reg     <= '0;
            write_data_reg   <= '0;
            write_strobe_reg <= 1'b0;
            receive_led_reg  <= 1'b0;
            frame_err_reg    <= 1'b0;
        end else begin
            write_strobe_reg <= strobe_next;
            frame_err_reg    <= frame_err;
            if (byte_valid) receive_led_reg <= ~receive_led_reg;
            if (strobe_next) write_data_reg <= win_shifted;

            if (word_state_reg == WORD_HUNT) begin
                if (byte_valid) begin
                    if (word_state_next == WORD_LOAD) begin
                        win_reg      <= '0;
                        byte_cnt_reg <= '0;
                    end else begin
                        win_reg <= win_shifted;
                    end
                end
            end else begin
                if (word_state_next == WORD_HUNT || frame_err) begin
                    win_reg      <= '0;
                    byte_cnt_reg <= '0;
                end else if (byte_valid) begin
                    win_reg      <= win_shifted;
                    byte_cnt_reg <= byte_cnt_reg + BYTE_CNT_W'(1);
                end
            end
        end
    end

    assign cfg.WriteData   = write_data_reg;
    assign cfg.WriteStrobe = write_strobe_reg;
    assign cfg.ComActive   = (word_state_reg == WORD_LOAD);
    assign cfg.ReceiveLED  = receive_led_reg;
    assign cfg.FrameErr    = frame_err_reg;

endmodule

// File: tb/tb_uart_cfg_loader.sv
// Directed bench for uart_cfg_loader at CLKS_PER_BIT = 8; the timeout step
// adapts to whether CFG_LOADER_TIMEOUT_EN is defined.
module tb_uart_cfg_loader;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int frame_cnt = 0;
    int led_toggles = 0;
    logic led_prev = 1'b0;
    int exp_strobes = 0;

    uart_cfg_loader_if cfg_bus ();

    uart_cfg_loader #(
        .CLKS_PER_BIT   (CPB),
        .SYNC_WORD      (32'hFAB0_FAB1),
        .DESYNC_WORD    (32'hFAB0_FAB0),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .Rx  (rx),
        .cfg (cfg_bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_bus.WriteStrobe) begin
            strobe_cnt <= strobe_cnt + 1;
            $display("strobe: WriteData=%08h", cfg_bus.WriteData);
        end
        if (cfg_bus.FrameErr) frame_cnt <= frame_cnt + 1;
        if (cfg_bus.ReceiveLED !== led_prev) led_toggles <= led_toggles + 1;
        led_prev <= cfg_bus.ReceiveLED;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_bit;
        repeat (CPB - 1) @(posedge clk);
        rx = 1'b1;
        $display("byte: %02h stop=%0b", b, stop_bit);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_write_data", cfg_bus.WriteData, 32'h0);
        check("reset_write_strobe", {31'b0, cfg_bus.WriteStrobe}, 32'h0);
        check("reset_com_active", {31'b0, cfg_bus.ComActive}, 32'h0);
        check("reset_receive_led", {31'b0, cfg_bus.ReceiveLED}, 32'h0);
        check("reset_frame_err", {31'b0, cfg_bus.FrameErr}, 32'h0);
        @(posedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Sync and load
        send_byte(8'hFA, 1'b1);
        send_byte(8'hB0, 1'b1);
        send_byte(8'hFA, 1'b1);
        @(negedge clk);
        check("sync_not_yet_active", {31'b0, cfg_bus.ComActive}, 32'h0);
        send_byte(8'hB1, 1'b1);
        @(negedge clk);
        check("sync_com_active", {31'b0, cfg_bus.ComActive}, 32'h1);
        send_word(32'h1234_5678);
        settle();
        exp_strobes = 1;
        check("load_strobe_count", strobe_cnt, exp_strobes);
        check("load_write_data", cfg_bus.WriteData, 32'h1234_5678);
        check("load_led_toggles", led_toggles, 8);

        // Desync, then data in HUNT is ignored
        send_word(32'hFAB0_FAB0);
        @(negedge clk);
        check("desync_com_active", {31'b0, cfg_bus.ComActive}, 32'h0);
        send_word(32'h1122_3344);
        settle();
        check("desync_no_strobe", strobe_cnt, exp_strobes);
        check("desync_data_held", cfg_bus.WriteData, 32'h1234_5678);

        // Pre-sync garbage
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_word(32'hFAB0_FAB1);
        send_word(32'hAABB_CCDD);
        settle();
        exp_strobes = 2;
        check("garbage_strobe_count", strobe_cnt, exp_strobes);
        check("garbage_write_data", cfg_bus.WriteData, 32'hAABB_CCDD);

        // Framing error drops the partial word
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        send_word(32'h0102_0304);
        settle();
        exp_strobes = 3;
        check("framing_err_count", frame_cnt, 1);
        check("framing_strobe_count", strobe_cnt, exp_strobes);
        check("framing_write_data", cfg_bus.WriteData, 32'h0102_0304);
        check("framing_com_active", {31'b0, cfg_bus.ComActive}, 32'h1);
        check("framing_led_toggles", led_toggles, 32);

        // Sync word inside LOAD realigns without a strobe
        send_word(32'hFAB0_FAB1);
        settle();
        check("resync_no_strobe", strobe_cnt, exp_strobes);
        check("resync_com_active", {31'b0, cfg_bus.ComActive}, 32'h1);
        send_word(32'h9ABC_DEF0);
        settle();
        exp_strobes = 4;
        check("resync_strobe_count", strobe_cnt, exp_strobes);
        check("resync_write_data", cfg_bus.WriteData, 32'h9ABC_DEF0);

        // Idle in LOAD with a partial word
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (250) @(posedge clk);
        @(negedge clk);
`ifdef CFG_LOADER_TIMEOUT_EN
        check("timeout_com_active", {31'b0, cfg_bus.ComActive}, 32'h0);
        send_word(32'h3344_5566);
        settle();
        check("timeout_no_strobe", strobe_cnt, exp_strobes);
`else
        check("no_timeout_com_active", {31'b0, cfg_bus.ComActive}, 32'h1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        settle();
        exp_strobes = 5;
        check("no_timeout_strobe_count", strobe_cnt, exp_strobes);
        check("no_timeout_write_data", cfg_bus.WriteData, 32'h1122_3344);
`endif
        send_word(32'hFAB0_FAB1);
        settle();
        check("reload_com_active", {31'b0, cfg_bus.ComActive}, 32'h1);

        // Reset in the middle of a byte while in LOAD
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        @(posedge clk);
        rx = 1'b0;
        repeat (30) @(posedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_com_active", {31'b0, cfg_bus.ComActive}, 32'h0);
        check("midreset_write_data", cfg_bus.WriteData, 32'h0);
        check("midreset_receive_led", {31'b0, cfg_bus.ReceiveLED}, 32'h0);
        @(posedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        send_word(32'h0304_0506);
        settle();
        check("midreset_no_strobe", strobe_cnt, exp_strobes);
        check("midreset_still_hunt", {31'b0, cfg_bus.ComActive}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cfg_loader.md
# uart_cfg_loader

UART bitstream loader for the eFPGA configuration path. It sits between the serial `Rx` pin and the fabric's configuration write port. It deserialises 8N1 bytes, hunts for a sync word, then packs the following bytes MSB-first into 32-bit words. Each complete word is presented to the frame/config logic as a single-cycle write strobe, alongside the `ComActive` and `ReceiveLED` status outputs.

## Interface
- `CLKS_PER_BIT`, 8: CLK cycles per UART bit. Must be even and ≥ 4.
- `SYNC_WORD`, 32'hFAB0_FAB1: word that enters LOAD from HUNT.
- `DESYNC_WORD`, 32'hFAB0_FAB0: word that, in LOAD, returns to HUNT without a strobe.
- `TIMEOUT_CYCLES`, 4096: idle cycles before LOAD is abandoned. Used only with `CFG_LOADER_TIMEOUT_EN`.
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `Rx`  in  1  asynchronous UART line, idle high.
- `WriteData`  out  32  assembled config word. Stable until the next strobe.
- `WriteStrobe`  out  1  one-cycle pulse: `WriteData` is valid.
- `ComActive`  out  1  high while in LOAD.
- `ReceiveLED`  out  1  toggles on every valid byte.
- `FrameErr`  out  1  one-cycle pulse on a bad stop bit.

## Operation
- `Rx` passes through a 2-flop synchroniser; both flops reset to 1.
- **Bit FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START: synced `Rx` is 0. Counter is loaded with `CLKS_PER_BIT/2-1`.
  - START, counter 0: if `Rx` is 0 → DATA; if `Rx` is 1 (glitch) → IDLE, no error.
  - DATA: samples every `CLKS_PER_BIT` cycles, LSB first, 8 bits → STOP.
  - STOP, sample point: if `Rx` is 1, internal `byte_valid` pulses for 1 cycle. If `Rx` is 0, `FrameErr` pulses and the byte is discarded. Either way → IDLE.
  - A start bit immediately following a stop bit is accepted with no required gap.
- **Word FSM states:** HUNT, LOAD.
  - HUNT: each valid byte shifts into a 32-bit window as `{win[23:0], byte}`. Window equal to `SYNC_WORD` → LOAD; byte count and window cleared.
  - LOAD: bytes packed MSB first. The 4th byte completes the word.
    - Completed word equal to `DESYNC_WORD` → HUNT, no strobe.
    - Completed word equal to `SYNC_WORD` → ignored (re-sync), no strobe, stays in LOAD.
    - Any other word → `WriteData` updated, `WriteStrobe` pulses.
- `FrameErr` in LOAD discards the partial word (byte count → 0) and stays in LOAD.
- `RST` mid-byte or mid-word: everything returns to reset state on that edge. Partial data is lost and no strobe is issued.

## Timing
- **Reset values:** `WriteData` 0, `WriteStrobe` 0, `ComActive` 0, `ReceiveLED` 0, `FrameErr` 0; bit FSM in IDLE, word FSM in HUNT.
- `Rx` falling edge to IDLE→START: 2 cycles of synchroniser latency.
- `byte_valid` occurs in the stop-bit sample cycle, which is 9.5·`CLKS_PER_BIT` cycles (+2 sync) after the start edge.
- `WriteStrobe`, `ReceiveLED` toggle, `ComActive` change, and `FrameErr` are all registered: they take effect 1 cycle after the `byte_valid` / stop-sample cycle.
- Minimum spacing between strobes is 4 bytes, i.e. 40·`CLKS_PER_BIT` cycles at 8N1 with no gaps.
- No backpressure: the consumer must accept every strobe.

## Configuration
- **`CFG_LOADER_TIMEOUT_EN` defined:**
  - An idle counter runs in LOAD. It clears on every `byte_valid` and every `FrameErr`.
  - When it reaches `TIMEOUT_CYCLES`, the word FSM returns to HUNT, the partial word is dropped, and `ComActive` falls on the next cycle.
- **`CFG_LOADER_TIMEOUT_EN` undefined:** no counter exists. LOAD is left only via `DESYNC_WORD` or `RST`.

## Structure
- **Package `cfg_loader_pkg`:**
  - bit-FSM and word-FSM state enums;
  - default `SYNC_WORD` / `DESYNC_WORD` constants;
  - byte-count width constant.
- **Sub-module `uart_rx_byte`:** synchroniser plus bit FSM. Outputs `byte`, `byte_valid`, `frame_err`. Parameterised by `CLKS_PER_BIT`.
- **Top level:** word FSM, packing logic and the optional timeout.

## Test plan
All scenarios use `CLKS_PER_BIT` = 8.
- **Reset:** `RST` high for 3 cycles with `Rx` = 1 → all outputs 0, `ComActive` 0.
- **Sync and load:** send FA B0 FA B1 then 12 34 56 78 → `ComActive` 1 one cycle after the 4th byte; single `WriteStrobe` with `WriteData` = 32'h1234_5678; `ReceiveLED` toggled 8 times.
- **Pre-sync garbage:** send 00 FF FA B0 FA B1 AA BB CC DD → exactly one strobe, data 32'hAABB_CCDD.
- **Framing error:** in LOAD, send 11 22, then a byte with stop bit 0, then 01 02 03 04 → one `FrameErr` pulse; one strobe with 32'h0102_0304.
- **Desync:** in LOAD, send FA B0 FA B0 → no strobe, `ComActive` 0 one cycle later; a following 11 22 33 44 produces no strobe.
- **Timeout and reset:**
  - With `CFG_LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 200, send sync + 2 bytes, then idle 250 cycles → `ComActive` drops; the next 4 bytes produce no strobe.
  - `RST` asserted mid-byte in LOAD → HUNT, no strobe.
